// File: rtl/axo_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between writeback sources,
// plus a per-register pending-write scoreboard used by decode to stall on hazards.
module axo_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NSRC = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      req_valid,
  output logic [NSRC-1:0]      req_ready,
  input  logic [NSRC*5-1:0]    req_rd,
  input  logic [NSRC*XLEN-1:0] req_data,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_din,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd,
  output logic                 alloc_ready,
  input  logic                 flush,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [31:0]     pending_reg, pending_next;
  logic            wb_we_reg;
  logic [4:0]      wb_rd_reg;
  logic [XLEN-1:0] wb_din_reg;

  logic [4:0]      src_rd   [NSRC];
  logic [XLEN-1:0] src_data [NSRC];
  logic [PW-1:0]   cand_idx [NSRC];

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [4:0]      grant_rd;
  logic [XLEN-1:0] grant_data;
  logic            alloc_fire;

  // cand_idx[k] is the k-th source visited in round-robin order from rr_ptr
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [PW:0] sum;
    assign src_rd[gi]   = req_rd[5*gi +: 5];
    assign src_data[gi] = req_data[XLEN*gi +: XLEN];
    assign sum          = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
    assign cand_idx[gi] = (sum >= (PW+1)'(NSRC)) ? PW'(sum - (PW+1)'(NSRC)) : PW'(sum);
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (!grant_found && rst && req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign grant_rd    = src_rd[grant_idx];
  assign grant_data  = src_data[grant_idx];
  assign rr_ptr_next = !grant_found ? rr_ptr_reg :
                       (grant_idx == PW'(NSRC-1)) ? '0 : grant_idx + 1'b1;

  assign alloc_ready = !pending_reg[alloc_rd] || (alloc_rd == 5'd0);
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_rd != 5'd0);
  assign rs1_busy    = (rs1 != 5'd0) && pending_reg[rs1];
  assign rs2_busy    = (rs2 != 5'd0) && pending_reg[rs2];

  // Clear happens at the regfile write edge; a flush drops any concurrent alloc
  always_comb begin
    pending_next = pending_reg;
    if (flush) begin
      pending_next = '0;
    end else begin
      if (wb_we_reg) pending_next[wb_rd_reg] = 1'b0;
      if (alloc_fire) pending_next[alloc_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg  <= '0;
      pending_reg <= '0;
      wb_we_reg   <= 1'b0;
      wb_rd_reg   <= '0;
      wb_din_reg  <= '0;
    end else begin
      rr_ptr_reg  <= rr_ptr_next;
      pending_reg <= pending_next;
      wb_we_reg   <= grant_found && (grant_rd != 5'd0);
      if (grant_found) begin
        wb_rd_reg  <= grant_rd;
        wb_din_reg <= grant_data;
      end
    end
  end

  assign wb_we  = wb_we_reg;
  assign wb_rd  = wb_rd_reg;
  assign wb_din = wb_din_reg;

endmodule

// File: tb/tb_axo_wb_arbiter.sv
// Randomized and directed bench for axo_wb_arbiter, checked against a
// behavioural model of round-robin grants, write latency and the scoreboard.
module tb_axo_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NSRC = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC-1:0]      req_valid;
  logic [NSRC-1:0]      req_ready;
  logic [NSRC*5-1:0]    req_rd;
  logic [NSRC*XLEN-1:0] req_data;
  logic                 wb_we;
  logic [4:0]           wb_rd;
  logic [XLEN-1:0]      wb_din;
  logic                 alloc_valid;
  logic [4:0]           alloc_rd;
  logic                 alloc_ready;
  logic                 flush;
  logic [4:0]           rs1, rs2;
  logic                 rs1_busy, rs2_busy;

  always #5 clk = ~clk;

  axo_wb_arbiter #(.XLEN(XLEN), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_data(req_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_din(wb_din),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .flush(flush), .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: next source to favour, pending set, expected write port
  int              m_rr;
  bit              m_pend [32];
  bit              m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_din;
  int              grant_log [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rr  = 0;
    m_we  = 0;
    m_rd  = '0;
    m_din = '0;
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
  endtask

  // First valid source met when walking the sources circularly from m_rr
  function automatic int model_grant();
    for (int k = 0; k < NSRC; k++) begin
      int i = (m_rr + k) % NSRC;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic raise(input int s, input logic [4:0] rd, input logic [XLEN-1:0] data);
    req_valid[s]           = 1'b1;
    req_rd[5*s +: 5]       = rd;
    req_data[XLEN*s +: XLEN] = data;
  endtask

  // One clock: check combinational outputs, advance the model, check write port
  task automatic step(input string tag);
    int              g;
    bit              exp_ar;
    logic [NSRC-1:0] exp_ready;
    logic [4:0]      g_rd;
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_ar = !m_pend[alloc_rd] || (alloc_rd == 5'd0);
    check_eq({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    check_eq({tag, ".alloc_ready"}, 64'(alloc_ready), 64'(exp_ar));
    check_eq({tag, ".rs1_busy"}, 64'(rs1_busy), 64'((rs1 != 0) && m_pend[rs1]));
    check_eq({tag, ".rs2_busy"}, 64'(rs2_busy), 64'((rs2 != 0) && m_pend[rs2]));
    @(posedge clk);
    if (flush) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      if (m_we) m_pend[m_rd] = 0;
      if (alloc_valid && exp_ar && alloc_rd != 0) m_pend[alloc_rd] = 1;
    end
    if (g >= 0) begin
      g_rd  = req_rd[5*g +: 5];
      m_we  = (g_rd != 0);
      m_rd  = g_rd;
      m_din = req_data[XLEN*g +: XLEN];
      m_rr  = (g + 1) % NSRC;
      grant_log.push_back(g);
      $display("%s grant src%0d rd=%0d data=%08h", tag, g, g_rd, m_din);
    end else begin
      m_we = 0;
    end
    #1;
    check_eq({tag, ".wb_we"}, 64'(wb_we), 64'(m_we));
    if (m_we) begin
      check_eq({tag, ".wb_rd"}, 64'(wb_rd), 64'(m_rd));
      check_eq({tag, ".wb_din"}, 64'(wb_din), 64'(m_din));
    end
    if (g >= 0) req_valid[g] = 1'b0;
    alloc_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    req_valid = '0; req_rd = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0;
    rs1 = 5'd5; rs2 = 5'd0; rst = 1'b0;
    model_reset();
    #12;
    check_eq("reset.wb_we", 64'(wb_we), 64'd0);
    check_eq("reset.wb_rd", 64'(wb_rd), 64'd0);
    check_eq("reset.wb_din", 64'(wb_din), 64'd0);
    check_eq("reset.ready", 64'(req_ready), 64'd0);
    check_eq("reset.alloc_ready", 64'(alloc_ready), 64'd1);
    check_eq("reset.busy", 64'(rs1_busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single write from source 1, then an idle cycle
    raise(1, 5'd5, 32'hDEADBEEF);
    step("single");
    step("single_idle");

    // All sources valid from reset: strict rotation 0,1,2,0,1,2
    do_reset();
    grant_log.delete();
    for (int s = 0; s < NSRC; s++) raise(s, 5'(10 + s), $urandom);
    for (int c = 0; c < 6; c++) begin
      step("rr");
      raise(grant_log[grant_log.size()-1], 5'(13 + c), $urandom);
    end
    for (int c = 0; c < 6; c++) check_eq("rr.order", 64'(grant_log[c]), 64'(c % 3));
    req_valid = '0;

    // Scoreboard on x7, and allocation of x0 never marks it busy
    alloc_valid = 1'b1; alloc_rd = 5'd7; rs1 = 5'd7; step("sb_alloc");
    raise(0, 5'd7, 32'h0000_0777); step("sb_grant");
    step("sb_wb");
    step("sb_clear");
    alloc_valid = 1'b1; alloc_rd = 5'd0; rs1 = 5'd0; step("sb_x0");
    step("sb_x0b");

    // Alloc of x9 in the same cycle its pending write lands
    alloc_valid = 1'b1; alloc_rd = 5'd9; rs1 = 5'd9; step("col_alloc");
    raise(0, 5'd9, 32'h0000_0999); step("col_grant");
    alloc_valid = 1'b1; alloc_rd = 5'd9; step("col_same");
    alloc_valid = 1'b1; alloc_rd = 5'd9; step("col_retry");
    step("col_busy");

    // Flush with x3 write in flight
    flush = 1'b1; step("fl_pre");
    alloc_valid = 1'b1; alloc_rd = 5'd3; step("fl_a3");
    alloc_valid = 1'b1; alloc_rd = 5'd4; step("fl_a4");
    alloc_valid = 1'b1; alloc_rd = 5'd5; step("fl_a5");
    raise(0, 5'd3, 32'h0000_3333); rs1 = 5'd4; rs2 = 5'd5; step("fl_grant");
    flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd6; step("fl_flush");
    rs1 = 5'd3; rs2 = 5'd6; step("fl_after");

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      for (int s = 0; s < NSRC; s++)
        if (!req_valid[s] && $urandom_range(0, 9) < 4)
          raise(s, 5'($urandom_range(0, 7)), $urandom);
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_rd    = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 24) == 0);
      step("rand");
    end

    // Asynchronous reset between edges with a write in flight and x12 pending
    flush = 1'b1; step("ar_clean");
    alloc_valid = 1'b1; alloc_rd = 5'd12; rs1 = 5'd12;
    for (int s = 0; s < NSRC; s++) raise(s, 5'(20 + s), $urandom);
    step("ar_grant");
    req_valid = '1;
    #2;
    rst = 1'b0;
    #1;
    check_eq("ar.wb_we", 64'(wb_we), 64'd0);
    check_eq("ar.wb_rd", 64'(wb_rd), 64'd0);
    check_eq("ar.busy", 64'(rs1_busy), 64'd0);
    check_eq("ar.ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step("ar_release");
    check_eq("ar.first_grant", 64'(grant_log[grant_log.size()-1]), 64'd0);
    req_valid = '0;
    step("ar_tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
